// File: rtl/div47_pkg.sv
// Shared constants and FSM state type for the constant-47 dividend reconstructor.
package div47_pkg;
    localparam int D_W      = 36;
    localparam int Q_W      = 31;
    localparam int R_W      = 6;
    localparam int CHUNK_W  = 9;
    localparam int DIVISOR  = 47;
    localparam int N_CHUNKS = D_W / CHUNK_W;
    localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div47_chunk_mac.sv
// One digit of the serial multiply-accumulate: {carry_out, d_chunk} = q_chunk*DIVISOR + carry_in.
module div47_chunk_mac
    import div47_pkg::*;
(
    input  logic [CHUNK_W-1:0] q_chunk,
    input  logic [R_W-1:0]     carry_in,
    output logic [CHUNK_W-1:0] d_chunk,
    output logic [R_W-1:0]     carry_out
);
    localparam int SUM_W = CHUNK_W + R_W;

    logic [SUM_W-1:0] sum;

    // Even with carry_in at its 6-bit maximum the high part stays below 2^R_W.
    assign sum       = SUM_W'(q_chunk) * SUM_W'(DIVISOR) + SUM_W'(carry_in);
    assign d_chunk   = sum[CHUNK_W-1:0];
    assign carry_out = sum[SUM_W-1:CHUNK_W];
endmodule

// File: rtl/div47_recon_serial.sv
// Digit-serial (LSB-first, CHUNK_W bits/cycle) rebuild of dividend = q*47 + r.
// Optional range check on err enabled by defining DIV47_RECON_CHECK_EN.
module div47_recon_serial
    import div47_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] q_in,
    input  logic [R_W-1:0] r_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] d_out,
    output logic           err
);
    state_t             state, state_nxt;
    logic [D_W-1:0]     q_sr;
    logic [D_W-1:0]     res;
    logic [R_W-1:0]     carry;
    logic [CNT_W-1:0]   cnt;
    logic               ld;
    logic               step_en;
    logic               last;
    logic [CHUNK_W-1:0] d_chunk;
    logic [R_W-1:0]     carry_out;

    assign last = (cnt == CNT_W'(N_CHUNKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        step_en   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    ld        = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step_en = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    div47_chunk_mac u_mac (
        .q_chunk   (q_sr[CHUNK_W-1:0]),
        .carry_in  (carry),
        .d_chunk   (d_chunk),
        .carry_out (carry_out)
    );

    // Result fills from the top so the first (least significant) chunk ends at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sr  <= '0;
            res   <= '0;
            carry <= '0;
            cnt   <= '0;
        end else if (ld) begin
            q_sr  <= {{(D_W-Q_W){1'b0}}, q_in};
            carry <= r_in;
            cnt   <= '0;
        end else if (step_en) begin
            q_sr  <= q_sr >> CHUNK_W;
            res   <= {d_chunk, res[D_W-1:CHUNK_W]};
            carry <= carry_out;
            cnt   <= cnt + 1'b1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign d_out     = res;

`ifdef DIV47_RECON_CHECK_EN
    logic r_bad;

    // A nonzero final carry means q*47+r overflowed D_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (ld)
                r_bad <= ({1'b0, r_in} >= (R_W+1)'(DIVISOR));
            if (step_en && last)
                err <= r_bad || (carry_out != '0);
            else if ((state == DONE) && out_ready)
                err <= 1'b0;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_div47_recon_serial.sv
// Directed bench for div47_recon_serial: reset, latency, boundaries, back-pressure, round-trip.
module tb_div47_recon_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [30:0] q_in = '0;
    logic [5:0]  r_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [35:0] d_out;
    logic        err;

    int total = 0;
    int bad   = 0;

`ifdef DIV47_RECON_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    div47_recon_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .r_in      (r_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer a pair, then expect out_valid on the 4th edge after the accepting edge.
    task automatic run_pair(input string tag, input logic [30:0] q, input logic [5:0] r,
                            input logic [35:0] exp_d, input logic exp_err);
        int n;
        q_in = q; r_in = r; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        chk({tag, "_rdy"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk({tag, "_early"}, out_valid, 1'b0);
        step();
        chk({tag, "_lat"}, out_valid, 1'b1);
        chk({tag, "_d"}, d_out, exp_d);
        chk({tag, "_err"}, err, exp_err);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ovclr"}, out_valid, 1'b0);
        chk({tag, "_errclr"}, err, 1'b0);
    endtask

    initial begin
        logic [35:0] x;
        logic [35:0] hold;

        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_d_out", d_out, 36'd0);
        chk("rst_err", err, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of RUN discards the partial result.
        q_in = 31'd1; r_in = 6'd46; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_d_out", d_out, 36'd0);
        step();
        rst_n = 1'b1;
        step();
        run_pair("q1r46", 31'd1, 6'd46, 36'd93, 1'b0);

        run_pair("typ", 31'd1462168, 6'd5, 36'd68721901, 1'b0);
        run_pair("zero", 31'd0, 6'd0, 36'd0, 1'b0);
        run_pair("maxok", 31'd1462116526, 6'd13, 36'hFFFFFFFFF, 1'b0);
        run_pair("ovf", 31'd1462116526, 6'd14, 36'd0, CHK);
        run_pair("r47", 31'd0, 6'd47, 36'd47, CHK);
        run_pair("r63", 31'd2, 6'd63, 36'd157, CHK);

        // Back-pressure: result held, new pair ignored until return to IDLE.
        q_in = 31'd100; r_in = 6'd7; in_valid = 1'b1;
        step();
        q_in = 31'd2; r_in = 6'd1;
        step(); step(); step();
        step();
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_d0", d_out, 36'd4707);
        hold = d_out;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_d", d_out, 36'd4707);
            chk("bp_hold_rdy", in_ready, 1'b0);
            chk("bp_hold_ov", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle_rdy", in_ready, 1'b1);
        chk("bp_idle_ov", out_valid, 1'b0);
        step();
        in_valid = 1'b0;
        chk("bp_acc_rdy", in_ready, 1'b0);
        step(); step(); step();
        chk("bp2_early", out_valid, 1'b0);
        step();
        chk("bp2_valid", out_valid, 1'b1);
        chk("bp2_d", d_out, 36'd95);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Random round-trip through true /47 quotient and residue.
        for (int i = 0; i < 300; i++) begin
            x = {4'($urandom_range(0, 15)), 32'($urandom())};
            run_pair("rt", 31'(x / 36'd47), 6'(x % 36'd47), x, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
